// File: rtl/clk_freq_divider.sv
// Integer clock divider: clk_out = clk_in / (sys_clk/desired_clk), 50% duty.
// Even ratios use a toggle flop; odd ratios OR a rising-edge phase with its falling-edge retimed copy.
`timescale 1ns/1ps
module clk_freq_divider #(
  parameter int unsigned sys_clk     = 50000000,
  parameter int unsigned desired_clk = 25000000
) (
  input  logic clk_in,
  input  logic nreset,
  output logic clk_out
);

  localparam int unsigned DIVISOR = (desired_clk > 0) ? desired_clk : 1;
  localparam int unsigned N       = sys_clk / DIVISOR;

  generate
    if (desired_clk == 0 || desired_clk > sys_clk || (sys_clk % DIVISOR) != 0) begin : g_bad_params
      $fatal(1, "clk_freq_divider: sys_clk must be a positive integer multiple of desired_clk");
    end
  endgenerate

  generate
    if (N == 1) begin : g_bypass
      assign clk_out = clk_in & ~nreset;

    end else if ((N % 2) == 0) begin : g_even
      localparam int unsigned     CW   = (N > 2) ? $clog2(N) : 1;
      localparam logic [CW-1:0]   LAST = CW'(N / 2 - 1);

      logic [CW-1:0] cnt;
      logic          out_q;

      always_ff @(posedge clk_in or posedge nreset) begin
        if (nreset) begin
          cnt   <= '0;
          out_q <= 1'b0;
        end else if (cnt == LAST) begin
          cnt   <= '0;
          out_q <= ~out_q;
        end else begin
          cnt   <= cnt + CW'(1);
        end
      end

      assign clk_out = out_q;

    end else begin : g_odd
      localparam int unsigned   CW       = $clog2(N);
      localparam logic [CW-1:0] LAST     = CW'(N - 1);
      localparam logic [CW-1:0] HIGH_CNT = CW'((N - 1) / 2);

      logic [CW-1:0] cnt;
      logic          ph_p;
      logic          ph_n;

      // ph_p is registered from the pre-increment count so it rises on the first edge after release
      always_ff @(posedge clk_in or posedge nreset) begin
        if (nreset) begin
          cnt  <= '0;
          ph_p <= 1'b0;
        end else begin
          cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
          ph_p <= (cnt < HIGH_CNT);
        end
      end

      always_ff @(negedge clk_in or posedge nreset) begin
        if (nreset) begin
          ph_n <= 1'b0;
        end else begin
          ph_n <= ph_p;
        end
      end

      // ph_p and ph_n change on opposite edges, so the OR cannot glitch
      assign clk_out = ph_p | ph_n;
    end
  endgenerate

endmodule

// File: tb/tb_clk_freq_divider.sv
// Directed bench for clk_freq_divider: ratios 2, 4, 3 and 1 driven from one 10ns clock.
`timescale 1ns/1ps
module tb_clk_freq_divider;

  logic clk_in;
  logic nreset;
  logic o2, o4, o3, o1;

  int checks   = 0;
  int failures = 0;

  clk_freq_divider #(.sys_clk(50000000), .desired_clk(25000000)) u_n2 (
    .clk_in(clk_in), .nreset(nreset), .clk_out(o2));
  clk_freq_divider #(.sys_clk(100), .desired_clk(25)) u_n4 (
    .clk_in(clk_in), .nreset(nreset), .clk_out(o4));
  clk_freq_divider #(.sys_clk(30), .desired_clk(10)) u_n3 (
    .clk_in(clk_in), .nreset(nreset), .clk_out(o3));
  clk_freq_divider #(.sys_clk(50), .desired_clk(50)) u_n1 (
    .clk_in(clk_in), .nreset(nreset), .clk_out(o1));

  // rises at 5,15,25,...; falls at 10,20,...
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // pulse widths of the N=3 output while the window is open
  bit  mon_en    = 1'b0;
  bit  have_prev = 1'b0;
  time last_t    = 0;
  int  widths_q[$];

  always @(o3) begin
    if (mon_en) begin
      if (have_prev) widths_q.push_back(int'($time - last_t));
      last_t    = $time;
      have_prev = 1'b1;
    end
  end

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  // rst: reset level driven for the half period ending at the sample
  // exp: {o2, o4, o3, o1} sampled 1ns after the next clk_in edge
  typedef struct {
    logic       rst;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{1'b1, 4'b0000};  // edge @5 rise, in reset
    vecs[1]  = '{1'b1, 4'b0000};  // @10
    vecs[2]  = '{1'b1, 4'b0000};  // @15 rise, N=1 gated off
    vecs[3]  = '{1'b1, 4'b0000};  // @20
    vecs[4]  = '{1'b0, 4'b1011};  // @25 first rise after release
    vecs[5]  = '{1'b0, 4'b1010};  // @30
    vecs[6]  = '{1'b0, 4'b0111};  // @35 N=4 first rise
    vecs[7]  = '{1'b0, 4'b0100};  // @40 N=3 low after 15ns
    vecs[8]  = '{1'b0, 4'b1101};  // @45
    vecs[9]  = '{1'b0, 4'b1100};  // @50
    vecs[10] = '{1'b0, 4'b0011};  // @55 N=3 high again, N=4 low
    vecs[11] = '{1'b0, 4'b0010};  // @60
    vecs[12] = '{1'b0, 4'b1011};  // @65
    vecs[13] = '{1'b0, 4'b1000};  // @70
    vecs[14] = '{1'b0, 4'b0101};  // @75 N=4 high again
    vecs[15] = '{1'b0, 4'b0100};  // @80

    nreset = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      nreset = vecs[i].rst;
      #5;
      check_bit($sformatf("vec%0d_n2", i), o2, vecs[i].exp[3]);
      check_bit($sformatf("vec%0d_n4", i), o4, vecs[i].exp[2]);
      check_bit($sformatf("vec%0d_n3", i), o3, vecs[i].exp[1]);
      check_bit($sformatf("vec%0d_n1", i), o1, vecs[i].exp[0]);
    end

    // t=81: N=4 output is mid-high; reset must pull it low without a clock edge
    #2;
    nreset = 1'b1;
    #1;
    check_bit("async_drop_n4", o4, 1'b0);
    check_bit("async_drop_n1", o1, 1'b0);

    @(posedge clk_in);
    #1;
    check_bit("held_n2", o2, 1'b0);
    check_bit("held_n4", o4, 1'b0);
    check_bit("held_n3", o3, 1'b0);
    check_bit("held_n1_clk_high", o1, 1'b0);

    nreset = 1'b0;
    begin
      int  edges = 0;
      bit  seen  = 1'b0;
      while (!seen && edges < 10) begin
        @(posedge clk_in);
        #1;
        edges++;
        if (edges == 1) begin
          check_bit("restart_n1_follows", o1, 1'b1);
          check_bit("restart_n2_first", o2, 1'b1);
          check_bit("restart_n3_first", o3, 1'b1);
        end
        if (o4) seen = 1'b1;
      end
      check_bit("restart_n4_rose", o4, 1'b1);
      check_int("restart_n4_latency", edges, 2);
    end

    // steady-state N=3 window: every interval between output changes must be 15ns
    mon_en = 1'b1;
    #80;
    mon_en = 1'b0;
    check_bit("n3_enough_edges", widths_q.size() >= 4, 1'b1);
    foreach (widths_q[k]) check_int($sformatf("n3_width%0d", k), widths_q[k], 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
